// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract sequencer: drives an external 4-bit ripple-carry adder one
// nibble per clock (LSB first) and collects the result, carry and signed overflow.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_cin,
  input  logic [3:0]             rca_s,
  input  logic                   rca_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE and out_valid only in DONE, so a
  // new request can never overlap an unconsumed result.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_reg, b_reg;
  logic            sub_reg;
  logic [IW-1:0]   idx;
  logic            carry_reg;
  logic            last;

  assign last = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rca_a     = 4'h0;
    rca_b     = 4'h0;
    rca_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        rca_a   = a_reg[{idx, 2'b00} +: 4];
        rca_b   = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};
        // Nibble 0 always takes sub as carry-in so nothing leaks between ops.
        rca_cin = (idx == '0) ? sub_reg : carry_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= rca_s;
          carry_reg                 <= rca_cout;
          if (last) begin
            idx      <= '0;
            cout     <= rca_cout;
            overflow <= (a_reg[W-1] == (b_reg[W-1] ^ sub_reg)) &&
                        (rca_s[3] != a_reg[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl: directed cases plus random
// operands against an integer-arithmetic reference model.
module tb_nibble_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          sub;
  logic          out_valid, out_ready;
  logic [W-1:0]  result;
  logic          cout, overflow;
  logic [3:0]    rca_a, rca_b, rca_s;
  logic          rca_cin, rca_cout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  cur_a, cur_b, exp_res;
  logic          cur_sub, exp_cout, exp_ovf;

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_s(rca_s), .rca_cout(rca_cout)
  );

  // The shared combinational 4-bit adder living outside the controller.
  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'h0, rca_cin};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    int sa, sb, sr;
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      sr       = sa - sb;
      exp_res  = ta - tb;
      exp_cout = (ta >= tb);
    end else begin
      sr       = sa + sb;
      exp_res  = ta + tb;
      exp_cout = ((int'(ta) + int'(tb)) >= (1 << W));
    end
    exp_ovf = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
  endtask

  function automatic logic [3:0] nib(input logic [W-1:0] v, input int k);
    return 4'(v >> (4*k));
  endfunction

  // Carry expected into nibble k: carry out of the low 4k bits of a + beff + sub.
  function automatic logic exp_cin(input int k);
    longint m, s;
    logic [W-1:0] beff;
    if (k == 0) return cur_sub;
    beff = cur_sub ? ~cur_b : cur_b;
    m = longint'(1) << (4*k);
    s = (longint'(cur_a) % m) + (longint'(beff) % m) + longint'(cur_sub);
    return (s >= m);
  endfunction

  // Present a request from a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    cur_a = ta; cur_b = tb; cur_sub = ts;
    model(ta, tb, ts);
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_and_check(input string tag);
    int lat;
    logic [W-1:0] beff;
    beff = cur_sub ? ~cur_b : cur_b;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (lat < NIBBLES) begin
        chk("rca_a", rca_a, nib(cur_a, lat));
        chk("rca_b", rca_b, nib(beff, lat));
        chk("rca_cin", rca_cin, exp_cin(lat));
        chk("in_ready_busy", in_ready, 0);
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, NIBBLES);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, cout, exp_cout);
    chk({tag, "_overflow"}, overflow, exp_ovf);
    chk({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_consume", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rca", {rca_a, rca_b, rca_cin}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h4321, 1'b0); wait_and_check("add_5555");   consume();
    issue(16'hFFFF, 16'h0001, 1'b0); wait_and_check("add_ripple"); consume();
    issue(16'h7FFF, 16'h0001, 1'b0); wait_and_check("add_ovf");    consume();
    issue(16'h0005, 16'h0007, 1'b1); wait_and_check("sub_borrow"); consume();
    issue(16'h8000, 16'h0001, 1'b1); wait_and_check("sub_ovf");    consume();

    // Backpressure: hold the result while a new request waits at the input.
    issue(16'h9ABC, 16'h1357, 1'b0); wait_and_check("bp_first");
    a = 16'h0F0F; b = 16'h00FF; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result", result, exp_res);
      chk("bp_cout", cout, exp_cout);
      chk("bp_overflow", overflow, exp_ovf);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released_out_valid", out_valid, 0);
    issue(16'h0F0F, 16'h00FF, 1'b1); wait_and_check("bp_second"); consume();

    // Asynchronous reset in the middle of a run.
    issue(16'hABCD, 16'h5678, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_idx2_rca_a", rca_a, nib(16'hABCD, 2));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_rca", {rca_a, rca_b, rca_cin}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    issue(16'h0001, 16'h0001, 1'b0); wait_and_check("post_rst"); consume();

    // Random operands, random idle gaps and consumer delays.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      issue(ra, rb, 1'($urandom_range(0, 1)));
      wait_and_check("rand");
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rand_hold_result", result, exp_res);
      end
      consume();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
